// File: rtl/smart_toilet_dispense_ctrl_pkg.sv
// Shared types and constants for the smart-toilet inlet dispense controller.
// Reagent indices double as the valve_o bit positions.
package smart_toilet_pkg;

    localparam int DOSE_W_DEFAULT = 16;

    localparam logic [1:0] REAG_SOLN1 = 2'd0;
    localparam logic [1:0] REAG_SOLN2 = 2'd1;
    localparam logic [1:0] REAG_SOLN3 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_OPEN,
        ST_PUMP,
        ST_CLOSE,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Highest-numbered reagent still waiting; soln3 has the longest channel and goes first.
    function automatic logic [1:0] top_reagent(input logic [2:0] mask);
        if (mask[2]) return REAG_SOLN3;
        else if (mask[1]) return REAG_SOLN2;
        return REAG_SOLN1;
    endfunction

    function automatic logic [2:0] reagent_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/smart_toilet_dispense_ctrl_if.sv
// Command/status bundle between the assay sequencer (master) and the dispense controller (slave).
interface smart_toilet_dispense_ctrl_if
    import smart_toilet_pkg::*;
#(
    parameter int DOSE_W = DOSE_W_DEFAULT
);
    logic              start_i;
    logic              abort_i;
    logic [DOSE_W-1:0] dose1_i;
    logic [DOSE_W-1:0] dose2_i;
    logic [DOSE_W-1:0] dose3_i;
    logic              flow_ok_i;
    logic [2:0]        valve_o;
    logic              pump_o;
    logic              busy_o;
    logic              done_o;
    logic              error_o;

    modport master (
        output start_i, abort_i, dose1_i, dose2_i, dose3_i, flow_ok_i,
        input  valve_o, pump_o, busy_o, done_o, error_o
    );

    modport slave (
        input  start_i, abort_i, dose1_i, dose2_i, dose3_i, flow_ok_i,
        output valve_o, pump_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/smart_toilet_dispense_ctrl_dose_timer.sv
// Loadable down-counter shared by the settle and dose intervals.
// A load of N keeps zero low for N cycles, so interval length L is loaded as L-1.
module dose_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/smart_toilet_dispense_ctrl.sv
// Inlet-stage sequencer: meters soln3, soln2, soln1 through valve/pump with settle
// intervals, watching the flow sensor during pumping. All outputs are registered.
module smart_toilet_dispense_ctrl
    import smart_toilet_pkg::*;
#(
    parameter int DOSE_W        = DOSE_W_DEFAULT,
    parameter int SETTLE_CYCLES = 8,
    parameter int FAULT_CYCLES  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    smart_toilet_dispense_ctrl_if.slave  bus
);
    localparam int FCW = $clog2(FAULT_CYCLES + 1);

    state_t            state, nxt_state;
    logic [1:0]        cur_idx, nxt_idx;
    logic [2:0]        pending;
    logic [DOSE_W-1:0] dose1_q, dose2_q, dose3_q, dose_sel, tmr_value;
    logic              tmr_load, tmr_zero, fault;
    logic [FCW-1:0]    fault_cnt;
    logic [2:0]        valve_q;
    logic              pump_q, busy_q, done_q, error_q;

    dose_timer #(.W(DOSE_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .en    (1'b1),
        .zero  (tmr_zero)
    );

    always_comb begin
        case (cur_idx)
            REAG_SOLN1: dose_sel = dose1_q;
            REAG_SOLN2: dose_sel = dose2_q;
            default:    dose_sel = dose3_q;
        endcase
    end

    assign fault = (state == ST_PUMP) && !bus.flow_ok_i &&
                   (fault_cnt == FCW'(FAULT_CYCLES - 1));

    // Abort outranks everything, including a fault detected on the same edge.
    always_comb begin
        nxt_state = state;
        nxt_idx   = cur_idx;
        tmr_load  = 1'b0;
        tmr_value = '0;
        if (bus.abort_i && (state != ST_IDLE)) begin
            nxt_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (bus.start_i) nxt_state = ST_LOAD;
                ST_LOAD: begin
                    nxt_state = ST_NEXT;
                    nxt_idx   = REAG_SOLN3;
                end
                ST_NEXT: begin
                    if (pending != 3'b000) begin
                        nxt_state = ST_OPEN;
                        nxt_idx   = top_reagent(pending);
                        tmr_load  = 1'b1;
                        tmr_value = DOSE_W'(SETTLE_CYCLES - 1);
                    end else begin
                        nxt_state = ST_DONE;
                    end
                end
                ST_OPEN: begin
                    if (tmr_zero) begin
                        nxt_state = ST_PUMP;
                        tmr_load  = 1'b1;
                        tmr_value = dose_sel - DOSE_W'(1);
                    end
                end
                ST_PUMP: begin
                    if (fault) begin
                        nxt_state = ST_ERROR;
                    end else if (tmr_zero) begin
                        nxt_state = ST_CLOSE;
                        tmr_load  = 1'b1;
                        tmr_value = DOSE_W'(SETTLE_CYCLES - 1);
                    end
                end
                ST_CLOSE: if (tmr_zero) nxt_state = ST_NEXT;
                ST_DONE:  nxt_state = ST_IDLE;
                ST_ERROR: nxt_state = ST_ERROR;
                default:  nxt_state = ST_IDLE;
            endcase
        end
    end

    // Zero-dose reagents never enter the pending mask, so NEXT skips them in no extra cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_idx   <= REAG_SOLN1;
            pending   <= 3'b000;
            dose1_q   <= '0;
            dose2_q   <= '0;
            dose3_q   <= '0;
            fault_cnt <= '0;
            valve_q   <= 3'b000;
            pump_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state   <= nxt_state;
            cur_idx <= nxt_idx;

            if (state == ST_LOAD) begin
                dose1_q <= bus.dose1_i;
                dose2_q <= bus.dose2_i;
                dose3_q <= bus.dose3_i;
                pending <= {bus.dose3_i != '0, bus.dose2_i != '0, bus.dose1_i != '0};
            end else if ((state == ST_NEXT) && (nxt_state == ST_OPEN)) begin
                pending <= pending & ~reagent_onehot(nxt_idx);
            end

            if ((nxt_state == ST_PUMP) && (state != ST_PUMP)) begin
                fault_cnt <= '0;
            end else if (state == ST_PUMP) begin
                fault_cnt <= bus.flow_ok_i ? '0 : fault_cnt + FCW'(1);
            end

            valve_q <= ((nxt_state == ST_OPEN) || (nxt_state == ST_PUMP)) ?
                       reagent_onehot(nxt_idx) : 3'b000;
            pump_q  <= (nxt_state == ST_PUMP);
            busy_q  <= !((nxt_state == ST_IDLE) || (nxt_state == ST_ERROR));
            done_q  <= (nxt_state == ST_DONE);
            error_q <= (nxt_state == ST_ERROR);
        end
    end

    assign bus.valve_o = valve_q;
    assign bus.pump_o  = pump_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.error_o = error_q;

endmodule

// File: tb/tb_smart_toilet_dispense_ctrl.sv
// Randomized bench for smart_toilet_dispense_ctrl: a per-cycle expected output trace is
// generated from the dosing rules and compared against the DUT every cycle.
module tb_smart_toilet_dispense_ctrl;

    localparam int DW     = 16;
    localparam int S      = 8;
    localparam int FAULTS = 4;

    typedef struct packed {
        logic [2:0] valve;
        logic       pump;
        logic       busy;
        logic       done;
        logic       error;
    } out_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    out_t exp_q[$];
    bit   flow_q[$];

    smart_toilet_dispense_ctrl_if #(.DOSE_W(DW)) bus ();

    smart_toilet_dispense_ctrl #(
        .DOSE_W        (DW),
        .SETTLE_CYCLES (S),
        .FAULT_CYCLES  (FAULTS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic [2:0] v, input logic p, input logic b,
                                input logic d, input logic e);
        return {v, p, b, d, e};
    endfunction

    function automatic out_t sample();
        return {bus.valve_o, bus.pump_o, bus.busy_o, bus.done_o, bus.error_o};
    endfunction

    // Flow sensor value during pump cycle k of reagent r for each stimulus mode.
    function automatic bit flow_fn(input int mode, input int r, input int k);
        case (mode)
            1:       return !((r == 1) && (k >= 7) && (k < 7 + FAULTS));
            2:       return (k % 4) == 3;
            3:       return $urandom_range(0, 9) >= 4;
            default: return 1'b1;
        endcase
    endfunction

    task automatic push(input out_t o, input bit f);
        exp_q.push_back(o);
        flow_q.push_back(f);
    endtask

    // Expected outputs per cycle, starting with the LOAD cycle after start is sampled.
    task automatic build_trace(input int d1, input int d2, input int d3, input int mode);
        int dose[3];
        int cnt;
        bit faulted;
        bit f;
        exp_q.delete();
        flow_q.delete();
        dose = '{d1, d2, d3};
        faulted = 1'b0;
        push(mk(3'b000, 0, 1, 0, 0), 1'($urandom_range(0, 1)));
        for (int r = 2; r >= 0 && !faulted; r--) begin
            if (dose[r] == 0) continue;
            push(mk(3'b000, 0, 1, 0, 0), 1'($urandom_range(0, 1)));
            repeat (S) push(mk(3'(1 << r), 0, 1, 0, 0), 1'($urandom_range(0, 1)));
            cnt = 0;
            for (int k = 0; k < dose[r]; k++) begin
                f = flow_fn(mode, r, k);
                push(mk(3'(1 << r), 1, 1, 0, 0), f);
                cnt = f ? 0 : cnt + 1;
                if (cnt == FAULTS) begin
                    faulted = 1'b1;
                    break;
                end
            end
            if (!faulted) repeat (S) push(mk(3'b000, 0, 1, 0, 0), 1'($urandom_range(0, 1)));
        end
        if (faulted) begin
            repeat (3) push(mk(3'b000, 0, 0, 0, 1), 1'($urandom_range(0, 1)));
        end else begin
            push(mk(3'b000, 0, 1, 0, 0), 1'($urandom_range(0, 1)));
            push(mk(3'b000, 0, 1, 1, 0), 1'($urandom_range(0, 1)));
            push(mk(3'b000, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
        end
    endtask

    // Runs one sequence; cut_at >= 0 ends it early by abort (or async reset if use_rst).
    task automatic run_seq(input string name, input int d1, input int d2, input int d3,
                           input int mode, input int cut_at, input bit use_rst);
        int   n;
        bit   cut;
        out_t got;
        build_trace(d1, d2, d3, mode);
        n   = exp_q.size();
        cut = (cut_at >= 0) && (cut_at < n);
        if (cut) n = cut_at + 1;
        bus.dose1_i   = DW'(d1);
        bus.dose2_i   = DW'(d2);
        bus.dose3_i   = DW'(d3);
        bus.abort_i   = 1'b0;
        bus.start_i   = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < n; c++) begin
            got = sample();
            tests_run++;
            if (got !== exp_q[c]) begin
                tests_failed++;
                $display("[TB] FAIL %s cycle %0d: got v/p/b/d/e=%b/%b/%b/%b/%b expected %b/%b/%b/%b/%b",
                         name, c, got.valve, got.pump, got.busy, got.done, got.error,
                         exp_q[c].valve, exp_q[c].pump, exp_q[c].busy, exp_q[c].done, exp_q[c].error);
            end
            bus.flow_ok_i = flow_q[c];
            bus.start_i   = (exp_q[c].busy || exp_q[c].error) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c >= 1) begin
                bus.dose1_i = DW'($urandom);
                bus.dose2_i = DW'($urandom);
                bus.dose3_i = DW'($urandom);
            end
            if (cut && use_rst && (c == n - 1)) begin
                bus.start_i = 1'b0;
                #3 rst = 1'b1;
                #1;
                got = sample();
                tests_run++;
                if (got !== mk(3'b000, 0, 0, 0, 0)) begin
                    tests_failed++;
                    $display("[TB] FAIL %s async_rst: got %b expected 0000000", name, got);
                end
                @(posedge clk); #2 rst = 1'b0;
                @(posedge clk); #1;
            end else begin
                if ((c == n - 1) && (cut || exp_q[c].error)) bus.abort_i = 1'b1;
                @(posedge clk); #1;
            end
        end
        got = sample();
        tests_run++;
        if (got !== mk(3'b000, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("[TB] FAIL %s idle_after: got %b expected 0000000", name, got);
        end
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        got = sample();
        tests_run++;
        if (got !== mk(3'b000, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("[TB] FAIL %s idle_hold: got %b expected 0000000", name, got);
        end
    endtask

    task automatic test_reset();
        out_t got;
        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.abort_i   = 1'b0;
        bus.flow_ok_i = 1'b1;
        bus.dose1_i   = '0;
        bus.dose2_i   = '0;
        bus.dose3_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        got = sample();
        tests_run++;
        if (got !== mk(3'b000, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got %b expected 0000000", got);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        got = sample();
        tests_run++;
        if (got !== mk(3'b000, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: got %b expected 0000000", got);
        end
    endtask

    task automatic test_nominal();
        run_seq("nominal", 10, 20, 30, 0, -1, 1'b0);
    endtask

    task automatic test_single_reagent();
        run_seq("single_soln2", 0, 5, 0, 0, -1, 1'b0);
    endtask

    task automatic test_all_zero();
        run_seq("all_zero", 0, 0, 0, 0, -1, 1'b0);
    endtask

    task automatic test_flow_fault();
        run_seq("flow_fault", 10, 20, 30, 1, -1, 1'b0);
    endtask

    task automatic test_flow_toggle();
        run_seq("flow_toggle", 10, 20, 30, 2, -1, 1'b0);
    endtask

    task automatic test_rst_mid_open();
        run_seq("rst_mid_open", 10, 20, 30, 0, 5, 1'b1);
        run_seq("after_rst", 10, 20, 30, 0, -1, 1'b0);
    endtask

    task automatic test_abort_mid_pump();
        run_seq("abort_mid_pump", 10, 20, 30, 0, 20, 1'b0);
        run_seq("after_abort", 10, 20, 30, 0, -1, 1'b0);
    endtask

    task automatic test_random();
        int d[3];
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 3; j++)
                d[j] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            run_seq($sformatf("random%0d", i), d[0], d[1], d[2], 3, -1, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_nominal();
        test_single_reagent();
        test_all_zero();
        test_flow_fault();
        test_flow_toggle();
        test_rst_mid_open();
        test_abort_mid_pump();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
